pixel_pll_sequencer: RTL and testbench
======================================

# pixel_pll_sequencer

Reset and lock sequencer for the 148.5 MHz pixel-clock PLL, running on the free-running 50 MHz reference clock. It holds the PLL in reset for a fixed time and releases it. It then waits for a debounced, stable lock before declaring the pixel domain ready, and recovers automatically from lock loss. If lock never arrives after a bounded number of attempts, it parks the PLL in a fault state until software requests a restart.

## Interface
- `RST_HOLD_CYCLES`, default 1000: refclk cycles `pll_rst` is held high per attempt (20 µs).
- `LOCK_TIMEOUT_CYCLES`, default 5_000_000: cycles allowed in WAIT_LOCK before an attempt counts as failed (100 ms).
- `LOCK_STABLE_CYCLES`, default 4096: consecutive locked cycles required before ready.
- `MAX_RETRIES`, default 3: consecutive timeouts that force FAULT.
- `refclk`, in, 1: single clock, 50 MHz.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `pll_locked`, in, 1: raw PLL `locked`; asynchronous to `refclk`.
- `restart`, in, 1: one-cycle pulse that forces a new sequence, for example after a mode change.
- `pll_rst`, out, 1: drives the PLL `rst` input, active-high.
- `pll_ready`, out, 1: PLL locked and stable; use it as the release condition for pixel-domain reset.
- `lock_lost`, out, 1: one-cycle pulse when lock drops while READY.
- `lock_loss_cnt`, out, 8: count of lock losses while READY; saturates at 255.
- `fault`, out, 1: retry budget exhausted.
- `state`, out, 3: current state encoding, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchronizer, reset to 0, producing `locked_s`. Its latency is 2 cycles.
- One shared cycle counter `cnt`, sized `$clog2` of the largest parameter. It is cleared on every state change.
- Per-state behaviour and transitions:
  - HOLD_RST: `pll_rst`=1. When `cnt`==RST_HOLD_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - If `locked_s`=1, go to STABLE.
    - Else, when `cnt`==LOCK_TIMEOUT_CYCLES-1, increment `retry`. If `retry`+1==MAX_RETRIES, go to FAULT; otherwise go to HOLD_RST.
  - STABLE: `pll_rst`=0.
    - If `locked_s`=0, go to WAIT_LOCK (glitch). The timeout restarts and `retry` is unchanged.
    - When `cnt`==LOCK_STABLE_CYCLES-1 with `locked_s`=1, go to READY and clear `retry`.
  - READY: `pll_ready`=1. If `locked_s`=0:
    - pulse `lock_lost`;
    - increment `lock_loss_cnt` (saturating);
    - go to HOLD_RST, so the PLL is fully re-reset.
  - FAULT: `pll_rst`=1 and `fault`=1, held indefinitely.
- `restart`=1 in any state goes to HOLD_RST, clears `cnt` and `retry`, and leaves `lock_loss_cnt` unchanged. It takes priority over every other transition in the same cycle.
- Outputs are Moore, decoded from the registered state. `lock_lost` is registered and coincides with the first HOLD_RST cycle.
- Reset values with `rst_n`=0:
  - `state`=HOLD_RST, `cnt`=0, `retry`=0;
  - `pll_rst`=1, `pll_ready`=0, `lock_lost`=0, `lock_loss_cnt`=0, `fault`=0;
  - synchronizer flops = 0.
- `rst_n` low mid-operation returns to these values on the next edge, whatever the state.
- `retry` width is `$clog2(MAX_RETRIES+1)`. It never exceeds MAX_RETRIES.

## Timing
- After `rst_n` rises, `pll_rst` stays high for exactly RST_HOLD_CYCLES cycles.
- With `locked_s` already 1 on entry to WAIT_LOCK, `pll_ready` rises LOCK_STABLE_CYCLES+1 cycles after `pll_rst` falls.
- Lock drop to `pll_ready` low: 3 cycles (2 synchronizer + 1 state register). `pll_rst` rises on the same edge.
- A failed attempt takes RST_HOLD_CYCLES+LOCK_TIMEOUT_CYCLES cycles.
- `restart` to `pll_rst` high: 1 cycle.

## Structure
- Package `pixel_pll_pkg` holds:
  - `pll_seq_state_t` enum: HOLD_RST=0, WAIT_LOCK=1, STABLE=2, READY=3, FAULT=4;
  - default parameter constants.
- Sub-module `sync_2ff` provides the single-bit synchronizer, with the same `refclk`/`rst_n` convention. It is reusable for other asynchronous status bits.
- Everything else lives in one flat FSM plus counter.

## Test plan
All scenarios use RST_HOLD_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=16, MAX_RETRIES=2.
- Clean lock: `pll_locked`=1 from reset release. Required: `pll_rst` high for cycles 0–7; `pll_ready` rises 17 cycles after `pll_rst` falls; `fault`=0.
- No lock: `pll_locked`=0 forever. Required: two HOLD/WAIT attempts; `fault` rises 144 cycles after reset release; `pll_rst`=1 thereafter. A subsequent `restart` pulse yields HOLD_RST with `retry`=0.
- Glitch during STABLE: `pll_locked` low for 3 cycles at STABLE count 10. Required: return to WAIT_LOCK; `retry` unchanged; `pll_ready` rises 17 cycles after `locked_s` recovers.
- Loss in READY, repeated 3 times. Required: each loss gives one `lock_lost` pulse, `pll_ready` low 3 cycles after the drop, and a new 8-cycle `pll_rst`; `lock_loss_cnt`=3. With 300 losses, the counter holds at 255.
- `restart` in the same cycle as the STABLE→READY condition. Required: next state is HOLD_RST and `pll_ready` never asserts.
- `rst_n` low for 1 cycle while READY. Required: all outputs at reset values on the next edge, including `lock_loss_cnt`=0 and `pll_rst`=1.

Source files
------------

// File: rtl/pixel_pll_pkg.sv
// Shared types and default timing constants for the pixel-clock PLL sequencer.
// Defaults assume a 50 MHz reference clock.
package pixel_pll_pkg;

  typedef enum logic [2:0] {
    HOLD_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;

  localparam int unsigned DEF_RST_HOLD_CYCLES     = 1000;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 5_000_000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 4096;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, synchronous active-low reset.
// Output follows the input with 2 refclk cycles of latency.
module sync_2ff (
  input  logic refclk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pixel_pll_sequencer.sv
// Reset/lock sequencer for the pixel-clock PLL: timed reset, debounced lock, bounded retries.
// Outputs are Moore decodes of the registered state; lock_lost is registered alongside it.
module pixel_pll_sequencer
  import pixel_pll_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned MAX_P  = max2(max2(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                                        max2(LOCK_STABLE_CYCLES, MAX_RETRIES));
  localparam int unsigned CNT_W  = ($clog2(MAX_P) < 1) ? 1 : $clog2(MAX_P);
  localparam int unsigned RTRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RETRY_LIMIT  = RTRY_W'(MAX_RETRIES);

  pll_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic [RTRY_W-1:0] retry_inc;
  logic              lost_q, lost_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;
  logic              locked_s;

  sync_2ff u_lock_sync (
    .refclk (refclk),
    .rst_n  (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  assign retry_inc = retry_q + RTRY_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    retry_d    = retry_q;
    lost_d     = 1'b0;
    loss_cnt_d = loss_cnt_q;
    if (restart) begin
      state_d = HOLD_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        HOLD_RST: if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? FAULT : HOLD_RST;
          end
        end
        STABLE: begin
          // A glitch restarts the lock wait without charging a retry.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = READY;
            retry_d = '0;
          end
        end
        READY: begin
          if (!locked_s) begin
            state_d = HOLD_RST;
            lost_d  = 1'b1;
            if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
          end
        end
        FAULT: state_d = FAULT;
        default: state_d = HOLD_RST;
      endcase
    end
    if (restart || (state_d != state_q) || (state_q == FAULT)) cnt_d = '0;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q    <= HOLD_RST;
      cnt_q      <= '0;
      retry_q    <= '0;
      lost_q     <= 1'b0;
      loss_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign pll_rst       = (state_q == HOLD_RST) || (state_q == FAULT);
  assign pll_ready     = (state_q == READY);
  assign fault         = (state_q == FAULT);
  assign lock_lost     = lost_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pixel_pll_sequencer.sv
// Directed bench for pixel_pll_sequencer with short timing parameters (8/64/16/2).
// Cycle c counts refclk edges after rst_n release; outputs are sampled 1 ns after each edge.
module tb_pixel_pll_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       pll_ready;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;
  logic       fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pixel_pll_sequencer #(
    .RST_HOLD_CYCLES     (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .LOCK_STABLE_CYCLES  (16),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_rst       (pll_rst),
    .pll_ready     (pll_ready),
    .lock_lost     (lock_lost),
    .lock_loss_cnt (lock_loss_cnt),
    .fault         (fault),
    .state         (state)
  );

  always #10 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset(input logic lk);
    rst_n      = 1'b0;
    restart    = 1'b0;
    pll_locked = lk;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks += 6;
    if (pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    if (pll_ready !== 1'b0) begin errors++; $display("FAIL reset_pll_ready got %b want 0", pll_ready); end
    if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
    if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_loss_cnt got %0d want 0", lock_loss_cnt); end
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
  endtask

  task automatic test_clean_lock();
    logic exp_rst, exp_rdy;
    do_reset(1'b1);
    for (int c = 0; c <= 30; c++) begin
      exp_rst = (c < 8);
      exp_rdy = (c >= 25);
      checks += 3;
      if (pll_rst !== exp_rst) begin errors++; $display("FAIL clean_pll_rst c=%0d got %b want %b", c, pll_rst, exp_rst); end
      if (pll_ready !== exp_rdy) begin errors++; $display("FAIL clean_pll_ready c=%0d got %b want %b", c, pll_ready, exp_rdy); end
      if (fault !== 1'b0) begin errors++; $display("FAIL clean_fault c=%0d got %b want 0", c, fault); end
      step();
    end
  endtask

  task automatic test_no_lock();
    logic exp_rst, exp_flt;
    do_reset(1'b0);
    for (int c = 0; c <= 150; c++) begin
      exp_rst = (c < 8) || (c >= 72 && c < 80) || (c >= 144);
      exp_flt = (c >= 144);
      checks += 2;
      if (pll_rst !== exp_rst) begin errors++; $display("FAIL nolock_pll_rst c=%0d got %b want %b", c, pll_rst, exp_rst); end
      if (fault !== exp_flt) begin errors++; $display("FAIL nolock_fault c=%0d got %b want %b", c, fault, exp_flt); end
      step();
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks += 2;
    if (state !== 3'd0) begin errors++; $display("FAIL nolock_restart_state got %0d want 0", state); end
    if (fault !== 1'b0) begin errors++; $display("FAIL nolock_restart_fault got %b want 0", fault); end
    // A cleared retry count means a full two-attempt sequence before FAULT again.
    for (int r = 0; r <= 145; r++) begin
      exp_flt = (r >= 144);
      checks++;
      if (fault !== exp_flt) begin errors++; $display("FAIL restart_fault r=%0d got %b want %b", r, fault, exp_flt); end
      step();
    end
  endtask

  task automatic test_glitch();
    logic exp_rdy;
    do_reset(1'b1);
    for (int c = 0; c <= 45; c++) begin
      exp_rdy = (c >= 41);
      checks++;
      if (pll_ready !== exp_rdy) begin errors++; $display("FAIL glitch_ready c=%0d got %b want %b", c, pll_ready, exp_rdy); end
      if (c == 21 || c == 22 || c == 25) begin
        checks++;
        if (state !== ((c == 22) ? 3'd1 : 3'd2)) begin
          errors++; $display("FAIL glitch_state c=%0d got %0d want %0d", c, state, (c == 22) ? 1 : 2);
        end
      end
      if (c == 19) pll_locked = 1'b0;
      if (c == 22) pll_locked = 1'b1;
      step();
    end
  endtask

  task automatic test_restart_race();
    do_reset(1'b1);
    for (int c = 0; c < 24; c++) step();
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL race_pre_state got %0d want 2", state); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks += 2;
    if (state !== 3'd0) begin errors++; $display("FAIL race_state got %0d want 0", state); end
    if (pll_rst !== 1'b1) begin errors++; $display("FAIL race_pll_rst got %b want 1", pll_rst); end
    for (int r = 0; r <= 25; r++) begin
      checks++;
      if (pll_ready !== (r == 25)) begin errors++; $display("FAIL race_ready r=%0d got %b want %b", r, pll_ready, (r == 25)); end
      step();
    end
  endtask

  task automatic test_loss_ready();
    int exp_cnt;
    logic full;
    do_reset(1'b1);
    for (int c = 0; c < 25; c++) step();
    checks++;
    if (pll_ready !== 1'b1) begin errors++; $display("FAIL loss_initial_ready got %b want 1", pll_ready); end
    for (int k = 1; k <= 300; k++) begin
      full = (k <= 3);
      exp_cnt = (k > 255) ? 255 : k;
      pll_locked = 1'b0;
      for (int c = 1; c <= 28; c++) begin
        step();
        if (full) begin
          checks += 3;
          if (pll_ready !== (c <= 2 || c == 28)) begin
            errors++; $display("FAIL loss_ready k=%0d c=%0d got %b", k, c, pll_ready);
          end
          if (lock_lost !== (c == 3)) begin
            errors++; $display("FAIL loss_pulse k=%0d c=%0d got %b", k, c, lock_lost);
          end
          if (pll_rst !== (c >= 3 && c <= 10)) begin
            errors++; $display("FAIL loss_pll_rst k=%0d c=%0d got %b", k, c, pll_rst);
          end
        end
        if (c == 3) begin
          pll_locked = 1'b1;
          checks++;
          if (lock_loss_cnt !== 8'(exp_cnt)) begin
            errors++; $display("FAIL loss_cnt k=%0d got %0d want %0d", k, lock_loss_cnt, exp_cnt);
          end
        end
      end
      if (!full && k % 50 == 0) begin
        checks++;
        if (pll_ready !== 1'b1) begin errors++; $display("FAIL loss_relock k=%0d got %b want 1", k, pll_ready); end
      end
    end
  endtask

  task automatic test_rst_in_ready();
    checks++;
    if (pll_ready !== 1'b1) begin errors++; $display("FAIL rstready_pre got %b want 1", pll_ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks += 6;
    if (pll_rst !== 1'b1) begin errors++; $display("FAIL rstready_pll_rst got %b want 1", pll_rst); end
    if (pll_ready !== 1'b0) begin errors++; $display("FAIL rstready_ready got %b want 0", pll_ready); end
    if (lock_lost !== 1'b0) begin errors++; $display("FAIL rstready_lost got %b want 0", lock_lost); end
    if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rstready_cnt got %0d want 0", lock_loss_cnt); end
    if (fault !== 1'b0) begin errors++; $display("FAIL rstready_fault got %b want 0", fault); end
    if (state !== 3'd0) begin errors++; $display("FAIL rstready_state got %0d want 0", state); end
    for (int c = 0; c <= 8; c++) begin
      checks++;
      if (pll_rst !== (c < 8)) begin errors++; $display("FAIL rstready_hold c=%0d got %b", c, pll_rst); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_no_lock();
    test_glitch();
    test_restart_race();
    test_loss_ready();
    test_rst_in_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
